enemy_fire_scheduler: RTL and testbench

Frame-rate scheduler that shares a pool of enemy missile slots among the 10 enemy columns. It decides when the next enemy shot is released, which column fires it, and where it spawns, then hands the shot to a free missile slot with a valid/ack handshake. It sits between the enemy array/player position logic and the per-slot missile movers, replacing free-running per-missile timers.

---
 rtl/invaders_pkg.sv | 50 +++++
 rtl/enemy_fire_scheduler_if.sv | 32 +++
 rtl/fire_lfsr8.sv | 26 ++
 rtl/enemy_fire_scheduler.sv | 179 +++++++++++++++++
 tb/tb_enemy_fire_scheduler.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/invaders_pkg.sv
// Shared constants, FSM encoding and small helpers for the enemy fire path.
package invaders_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCooldown,
    StSearch,
    StIssue
  } fire_state_t;

  localparam int unsigned NUM_COLS = 10;
  localparam int unsigned NUM_ROWS = 6;

  localparam logic [3:0] RUN_STATE = 4'd1;

  localparam logic [7:0] COOLDOWN_L0 = 8'd30;
  localparam logic [7:0] COOLDOWN_L1 = 8'd20;
  localparam logic [7:0] COOLDOWN_L2 = 8'd12;
  localparam logic [7:0] COOLDOWN_L3 = 8'd8;

  localparam logic [9:0] ROW0_Y           = 10'd64;
  localparam logic [9:0] ROW_PITCH        = 10'd32;
  localparam logic [9:0] MISSILE_X_CENTER = 10'd16;

  function automatic logic [7:0] cooldown_limit(input logic [1:0] level);
    logic [7:0] lim;
    unique case (level)
      2'd0:    lim = COOLDOWN_L0;
      2'd1:    lim = COOLDOWN_L1;
      2'd2:    lim = COOLDOWN_L2;
      default: lim = COOLDOWN_L3;
    endcase
    return lim;
  endfunction

  // Highest set bit is the lowest alive enemy in the column (row 5 is the bottom).
  function automatic logic [2:0] top_row(input logic [NUM_ROWS-1:0] col_status);
    logic [2:0] row;
    row = '0;
    for (int r = 0; r < int'(NUM_ROWS); r++) begin
      if (col_status[r]) row = 3'(r);
    end
    return row;
  endfunction

  function automatic logic [9:0] row_y(input logic [2:0] row);
    return ROW0_Y + ROW_PITCH * {7'd0, row};
  endfunction

endpackage

// File: rtl/enemy_fire_scheduler_if.sv
// Shot request handshake between the fire scheduler and the missile slot movers.
interface enemy_fire_scheduler_if #(
  parameter int unsigned NSLOT = 3
);
  logic [NSLOT-1:0] slot_busy;
  logic             fire_ack;
  logic             fire_valid;
  logic [NSLOT-1:0] fire_slot;
  logic [9:0]       fire_x;
  logic [9:0]       fire_y;
  logic [2:0]       fire_speed;

  modport master (
    input  slot_busy,
    input  fire_ack,
    output fire_valid,
    output fire_slot,
    output fire_x,
    output fire_y,
    output fire_speed
  );

  modport slave (
    output slot_busy,
    output fire_ack,
    input  fire_valid,
    input  fire_slot,
    input  fire_x,
    input  fire_y,
    input  fire_speed
  );
endinterface

// File: rtl/fire_lfsr8.sv
// 8-bit Galois LFSR (x^8 + x^6 + x^5 + x^4 + 1) with enable; reset loads the seed.
module fire_lfsr8 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [7:0] seed_i,
  output logic [7:0] lfsr_o
);
  localparam logic [7:0] TapMask = 8'hB8;

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? TapMask : 8'h00);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= seed_i;
    else         lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;
endmodule

// File: rtl/enemy_fire_scheduler.sv
// Frame-rate enemy shot scheduler: cooldown, column search, slot handshake.
// Optional ENEMY_FIRE_RANDOM_EN alternates the search start column with an LFSR pick.
module enemy_fire_scheduler
  import invaders_pkg::*;
#(
  parameter int unsigned NSLOT = 3
) (
  input  logic                               vsync_i,
  input  logic                               reset_ni,
  input  logic [3:0]                         state_i,
  input  logic [1:0]                         level_i,
  input  logic [9:0]                         player_x_i,
  input  logic [9:0]                         enemy_offset_i,
  input  logic [NUM_COLS-1:0][NUM_ROWS-1:0]  enemy_status_i,
  enemy_fire_scheduler_if.master             fire_if
);

  fire_state_t      fsm_q, fsm_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       scan_q, scan_d;
  logic             valid_q, valid_d;
  logic [NSLOT-1:0] slot_q, slot_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic [2:0]       speed_q, speed_d;

  logic [3:0]          player_col;
  logic [3:0]          start_col;
  logic [NSLOT-1:0]    free;
  logic [NSLOT-1:0]    free_oh;
  logic                any_free;
  logic [NUM_ROWS-1:0] col_status;
  logic                unused_px;

  assign unused_px  = ^player_x_i[5:0];
  assign player_col = (player_x_i[9:6] > 4'd9) ? 4'd9 : player_x_i[9:6];

`ifdef ENEMY_FIRE_RANDOM_EN
  logic [7:0] lfsr;
  logic [3:0] lfsr_col;
  logic       shot_odd_q, shot_odd_d;
  logic       unused_lfsr;

  fire_lfsr8 u_lfsr (
    .clk_i  (vsync_i),
    .rst_ni (reset_ni),
    .en_i   (1'b1),
    .seed_i (8'h5A),
    .lfsr_o (lfsr)
  );

  assign unused_lfsr = ^lfsr[7:4];
  assign lfsr_col    = (lfsr[3:0] >= 4'd10) ? lfsr[3:0] - 4'd10 : lfsr[3:0];
  assign start_col   = shot_odd_q ? lfsr_col : player_col;

  always_ff @(posedge vsync_i or negedge reset_ni) begin
    if (!reset_ni) shot_odd_q <= 1'b0;
    else           shot_odd_q <= shot_odd_d;
  end
`else
  assign start_col = player_col;
`endif

  // Lowest-index free slot as a one-hot mask.
  assign free       = ~fire_if.slot_busy;
  assign free_oh    = free & (~free + NSLOT'(1));
  assign any_free   = |free;
  assign col_status = enemy_status_i[cand_q];

  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    scan_d  = scan_q;
    valid_d = valid_q;
    slot_d  = slot_q;
    x_d     = x_q;
    y_d     = y_q;
    speed_d = speed_q;
`ifdef ENEMY_FIRE_RANDOM_EN
    shot_odd_d = shot_odd_q;
`endif

    if (state_i != RUN_STATE) begin
      fsm_d   = StIdle;
      cnt_d   = '0;
      cand_d  = '0;
      scan_d  = '0;
      valid_d = 1'b0;
      slot_d  = '0;
      x_d     = '0;
      y_d     = '0;
      speed_d = 3'd1;
    end else begin
      unique case (fsm_q)
        StIdle: fsm_d = StCooldown;

        StCooldown: begin
          if (cnt_q >= cooldown_limit(level_i) - 8'd1) begin
            cnt_d  = '0;
            cand_d = start_col;
            scan_d = '0;
            fsm_d  = StSearch;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        StSearch: begin
          if (col_status == '0) begin
            if (scan_q == 4'd9) begin
              // Whole array is cleared: skip this shot.
              fsm_d = StCooldown;
              cnt_d = '0;
            end else begin
              scan_d = scan_q + 4'd1;
              cand_d = (cand_q == 4'd9) ? 4'd0 : cand_q + 4'd1;
            end
          end else if (any_free) begin
            fsm_d   = StIssue;
            valid_d = 1'b1;
            slot_d  = free_oh;
            x_d     = {cand_q, 6'b0} + enemy_offset_i + MISSILE_X_CENTER;
            y_d     = row_y(top_row(col_status));
            speed_d = {1'b0, level_i} + 3'd1;
`ifdef ENEMY_FIRE_RANDOM_EN
            shot_odd_d = ~shot_odd_q;
`endif
          end
        end

        StIssue: begin
          if (fire_if.fire_ack) begin
            valid_d = 1'b0;
            slot_d  = '0;
            cnt_d   = '0;
            fsm_d   = StCooldown;
          end else if (|(slot_q & fire_if.slot_busy) && any_free) begin
            slot_d = free_oh;
          end
        end

        default: fsm_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge vsync_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fsm_q   <= StIdle;
      cnt_q   <= '0;
      cand_q  <= '0;
      scan_q  <= '0;
      valid_q <= 1'b0;
      slot_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      speed_q <= 3'd1;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      scan_q  <= scan_d;
      valid_q <= valid_d;
      slot_q  <= slot_d;
      x_q     <= x_d;
      y_q     <= y_d;
      speed_q <= speed_d;
    end
  end

  assign fire_if.fire_valid = valid_q;
  assign fire_if.fire_slot  = slot_q;
  assign fire_if.fire_x     = x_q;
  assign fire_if.fire_y     = y_q;
  assign fire_if.fire_speed = speed_q;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Scoreboard bench for enemy_fire_scheduler: expected shots queued with stimulus.
module tb_enemy_fire_scheduler;
  localparam int unsigned NSLOT = 3;

  logic             vsync   = 1'b0;
  logic             reset_n = 1'b0;
  logic [3:0]       state;
  logic [1:0]       level;
  logic [9:0]       player_x;
  logic [9:0]       enemy_offset;
  logic [9:0][5:0]  enemy_status;

  enemy_fire_scheduler_if #(.NSLOT(NSLOT)) fire_if ();

  enemy_fire_scheduler #(.NSLOT(NSLOT)) dut (
    .vsync_i        (vsync),
    .reset_ni       (reset_n),
    .state_i        (state),
    .level_i        (level),
    .player_x_i     (player_x),
    .enemy_offset_i (enemy_offset),
    .enemy_status_i (enemy_status),
    .fire_if        (fire_if)
  );

  always #5 vsync = ~vsync;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] slot;
    logic [2:0] speed;
  } shot_t;

  shot_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge vsync);
    @(negedge vsync);
  endtask

  task automatic wait_valid(input int limit, output int frames);
    frames = 0;
    while (!fire_if.fire_valid && frames < limit) begin
      step();
      frames++;
    end
  endtask

  task automatic expect_shot(input string tag, input int limit, input int exp_frames);
    int    frames;
    shot_t s;
    wait_valid(limit, frames);
    check_eq({tag, "_latency"}, frames, exp_frames);
    check_eq({tag, "_valid"}, {31'd0, fire_if.fire_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_sb: got a shot, expected none queued", tag);
    end else begin
      s = exp_q.pop_front();
      check_eq({tag, "_x"},     {22'd0, fire_if.fire_x},     {22'd0, s.x});
      check_eq({tag, "_y"},     {22'd0, fire_if.fire_y},     {22'd0, s.y});
      check_eq({tag, "_slot"},  {29'd0, fire_if.fire_slot},  {29'd0, s.slot});
      check_eq({tag, "_speed"}, {29'd0, fire_if.fire_speed}, {29'd0, s.speed});
    end
  endtask

  task automatic ack_shot(input string tag);
    fire_if.fire_ack = 1'b1;
    step();
    fire_if.fire_ack = 1'b0;
    check_eq({tag, "_ack_valid"}, {31'd0, fire_if.fire_valid}, 32'd0);
    check_eq({tag, "_ack_slot"},  {29'd0, fire_if.fire_slot},  32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, {31'd0, fire_if.fire_valid}, 32'd0);
    check_eq({tag, "_slot"},  {29'd0, fire_if.fire_slot},  32'd0);
    check_eq({tag, "_x"},     {22'd0, fire_if.fire_x},     32'd0);
    check_eq({tag, "_y"},     {22'd0, fire_if.fire_y},     32'd0);
    check_eq({tag, "_speed"}, {29'd0, fire_if.fire_speed}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int frames;
    state             = 4'd1;
    level             = 2'd0;
    player_x          = 10'd130;
    enemy_offset      = 10'd0;
    enemy_status      = {10{6'h3F}};
    fire_if.slot_busy = '0;
    fire_if.fire_ack  = 1'b0;

    repeat (2) @(negedge vsync);
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // Level 0, column 2 from playerX=130, bottom row alive.
    exp_q.push_back(shot_t'{x: 10'd144, y: 10'd224, slot: 3'b001, speed: 3'd1});
    expect_shot("lvl0", 60, 32);

    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("hold_valid", {31'd0, fire_if.fire_valid}, 32'd1);
      check_eq("hold_x", {22'd0, fire_if.fire_x}, 32'd144);
      check_eq("hold_slot", {29'd0, fire_if.fire_slot}, 32'd1);
    end

    level = 2'd3;
    ack_shot("lvl0");
    exp_q.push_back(shot_t'{x: 10'd144, y: 10'd224, slot: 3'b001, speed: 3'd4});
    expect_shot("lvl3", 30, 9);

    // Columns 0..2 cleared, column 3 has rows 0 and 1.
    player_x        = 10'd0;
    enemy_status[0] = 6'b0;
    enemy_status[1] = 6'b0;
    enemy_status[2] = 6'b0;
    enemy_status[3] = 6'b000011;
    ack_shot("lvl3");
    exp_q.push_back(shot_t'{x: 10'd208, y: 10'd96, slot: 3'b001, speed: 3'd4});
    expect_shot("skip", 30, 12);

    // No free slot: search must stall.
    enemy_status      = {10{6'h3F}};
    player_x          = 10'd130;
    fire_if.slot_busy = 3'b111;
    ack_shot("skip");
    wait_valid(20, frames);
    check_eq("busy_stall_frames", frames, 20);
    check_eq("busy_stall_valid", {31'd0, fire_if.fire_valid}, 32'd0);

    fire_if.slot_busy = 3'b101;
    exp_q.push_back(shot_t'{x: 10'd144, y: 10'd224, slot: 3'b010, speed: 3'd4});
    expect_shot("free1", 3, 1);

    // Target goes busy with nothing free: hold old slot.
    fire_if.slot_busy = 3'b111;
    step();
    check_eq("allbusy_valid", {31'd0, fire_if.fire_valid}, 32'd1);
    check_eq("allbusy_slot", {29'd0, fire_if.fire_slot}, 32'b010);
    // Slot 0 frees: re-select it.
    fire_if.slot_busy = 3'b110;
    step();
    check_eq("reselect_slot", {29'd0, fire_if.fire_slot}, 32'b001);
    check_eq("reselect_valid", {31'd0, fire_if.fire_valid}, 32'd1);

    // Leaving the run state mid-handshake clears everything.
    state = 4'd2;
    step();
    check_reset_outputs("state2");
    step();
    check_eq("state2_idle_valid", {31'd0, fire_if.fire_valid}, 32'd0);

    state = 4'd1;
    exp_q.push_back(shot_t'{x: 10'd144, y: 10'd224, slot: 3'b001, speed: 3'd4});
    expect_shot("rerun", 30, 10);

    // Asynchronous reset between edges.
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge vsync);
    reset_n = 1'b1;

    // Cleared array: never a shot.
    enemy_status      = '0;
    fire_if.slot_busy = '0;
    wait_valid(100, frames);
    check_eq("empty_frames", frames, 100);
    check_eq("empty_valid", {31'd0, fire_if.fire_valid}, 32'd0);

    // Saturated player column 9 and spawn-X wrap-around: 576+500+16 = 1092 -> 68.
    enemy_status[9] = 6'b100000;
    player_x        = 10'h3FF;
    enemy_offset    = 10'd500;
    reset_n         = 1'b0;
    @(negedge vsync);
    reset_n = 1'b1;
    exp_q.push_back(shot_t'{x: 10'd68, y: 10'd224, slot: 3'b001, speed: 3'd4});
    expect_shot("sat_wrap", 30, 10);

    // Ack while idle must be ignored.
    ack_shot("sat_wrap");
    fire_if.fire_ack = 1'b1;
    step();
    fire_if.fire_ack = 1'b0;
    check_eq("stray_ack_valid", {31'd0, fire_if.fire_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
